// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, stop-bit check and framing-error pulse
module uart_rx #(
  parameter int TICK_DIV   = 651,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int              DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_MAX  = DW'(TICK_DIV - 1);
  localparam logic [3:0]      MID_SMP  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      LAST_SMP = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;

  state_t        state, state_d;
  logic [3:0]    sample_cnt, sample_cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed, armed_d;
  logic          valid_set, err_set;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      armed      <= 1'b1;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      sample_cnt <= sample_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shift_q    <= shift_d;
      armed      <= armed_d;
      data_valid <= valid_set;
      frame_err  <= err_set;
      if (valid_set) data_out <= shift_q;
    end
  end

  // Everything below only moves on an oversample tick; between ticks the state is frozen.
  always_comb begin
    state_d      = state;
    sample_cnt_d = sample_cnt;
    bit_cnt_d    = bit_cnt;
    shift_d      = shift_q;
    armed_d      = armed;
    if (tick) begin
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end
        START: begin
          if (sample_cnt == MID_SMP) begin
            if (!rx_s) begin
              state_d      = DATA;
              sample_cnt_d = '0;
              bit_cnt_d    = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt + 4'd1;
          end
        end
        DATA: begin
          if (sample_cnt == LAST_SMP) begin
            shift_d[bit_cnt] = rx_s;
            sample_cnt_d     = '0;
            if (bit_cnt == 3'd7) state_d = STOP;
            else                 bit_cnt_d = bit_cnt + 3'd1;
          end else begin
            sample_cnt_d = sample_cnt + 4'd1;
          end
        end
        STOP: begin
          // A low stop bit disarms start detection until the line is seen high again.
          if (sample_cnt == LAST_SMP) begin
            state_d = IDLE;
            if (!rx_s) armed_d = 1'b0;
          end else begin
            sample_cnt_d = sample_cnt + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_set = 1'b0;
    err_set   = 1'b0;
    if (tick && state == STOP && sample_cnt == LAST_SMP) begin
      valid_set = rx_s;
      err_set   = !rx_s;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: vector table, corner sequences, random frames vs model
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT      = TICK_DIV * 16;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       rx_in  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, busy;

  uart_rx #(.TICK_DIV(TICK_DIV)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         valid_cyc = 0;
  int         n_valid = 0, n_ferr = 0, n_both = 0, n_wide = 0;
  bit         busy_seen = 1'b0;
  logic       prev_pulse = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (data_valid) begin
      n_valid++;
      valid_cyc = cyc;
      got_q.push_back(data_out);
    end
    if (frame_err) n_ferr++;
    if (data_valid && frame_err) n_both++;
    if ((data_valid || frame_err) && prev_pulse) n_wide++;
    prev_pulse = data_valid || frame_err;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the line for n clocks; always leaves the caller 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx_in = v;
    if (n > 0) begin
      repeat (n) @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low,
                            input int rst_bit, output logic low_busy);
    low_busy  = 1'b0;
    start_cyc = cyc;
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        hold(d[i], BIT / 2);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        rst   = 1'b0;
        rx_in = 1'b1;
        return;
      end
      hold(d[i], BIT);
    end
    hold(stop, BIT);
    if (extra_low > 0) begin
      busy_seen = 1'b0;
      hold(1'b0, extra_low * BIT);
      low_busy = busy_seen;
    end
    rx_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         extra_low;
    int         gap_bits;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t       vecs[5];
  int         v0, e0, lat, gap, extra;
  logic       low_busy, stop_b;
  logic [7:0] d, last_good;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0, 2, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 2, 2, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 0, 2, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 0, 0, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 0, 2, 1, 0, 8'hFF};

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_valid", data_valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset busy", busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, 2 * BIT);

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid;
      e0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].extra_low, -1, low_busy);
      chk($sformatf("vec%0d valid pulses", i), n_valid - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d frame_err pulses", i), n_ferr - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_dout);
      if (vecs[i].extra_low > 0)
        chk($sformatf("vec%0d busy while line held low", i), low_busy, 1'b0);
      if (vecs[i].exp_valid == 1) begin
        lat = valid_cyc - start_cyc;
        chk($sformatf("vec%0d latency %0d within 600..616", i, lat), (lat >= 600 && lat <= 616), 1'b1);
      end
      hold(1'b1, vecs[i].gap_bits * BIT);
      if (vecs[i].gap_bits > 0)
        chk($sformatf("vec%0d busy after frame", i), busy, 1'b0);
    end

    v0 = n_valid;
    e0 = n_ferr;
    busy_seen = 1'b0;
    hold(1'b0, 8);
    hold(1'b1, 2 * BIT);
    chk("glitch busy rose", busy_seen, 1'b1);
    chk("glitch busy fell", busy, 1'b0);
    chk("glitch valid pulses", n_valid - v0, 0);
    chk("glitch frame_err pulses", n_ferr - e0, 0);
    chk("glitch data_out", data_out, 8'hFF);

    v0 = n_valid;
    e0 = n_ferr;
    send_frame(8'h77, 1'b1, 0, 4, low_busy);
    chk("midframe rst busy", busy, 1'b0);
    chk("midframe rst data_out", data_out, 8'h00);
    hold(1'b1, 2 * BIT);
    chk("midframe rst pulses", (n_valid - v0) + (n_ferr - e0), 0);
    send_frame(8'h5A, 1'b1, 0, -1, low_busy);
    chk("after rst valid pulses", n_valid - v0, 1);
    chk("after rst data_out", data_out, 8'h5A);
    hold(1'b1, BIT);

    last_good = 8'h5A;
    for (int i = 0; i < 30; i++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      extra  = stop_b ? 0 : int'($urandom_range(0, 2));
      gap    = stop_b ? int'($urandom_range(0, 3 * BIT)) : int'($urandom_range(BIT, 3 * BIT));
      v0 = n_valid;
      e0 = n_ferr;
      got_q.delete();
      send_frame(d, stop_b, extra, -1, low_busy);
      if (stop_b) last_good = d;
      chk($sformatf("rand%0d valid pulses", i), n_valid - v0, stop_b ? 1 : 0);
      chk($sformatf("rand%0d frame_err pulses", i), n_ferr - e0, stop_b ? 0 : 1);
      chk($sformatf("rand%0d data_out", i), data_out, last_good);
      if (stop_b && got_q.size() > 0)
        chk($sformatf("rand%0d byte at pulse", i), got_q[0], d);
      hold(1'b1, gap);
    end

    chk("never both pulses high", n_both, 0);
    chk("pulses one cycle wide", n_wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
